// File: rtl/sd_sector_arbiter.sv
// Two-requester round-robin arbiter sharing one user_io SD sector channel.
// Optional GRANT-phase ack timeout enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  req_din0,
  input  logic [7:0]  req_din1,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  req_grant,
  output logic [1:0]  req_dout_strobe,
  output logic [1:0]  req_din_strobe,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe,
  output logic [7:0]  sd_din
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant_q, grant_nxt;
  logic [1:0]  done_q, done_nxt;
  logic        last_q, last_nxt;
  logic        rd_q, rd_nxt;
  logic        wr_q, wr_nxt;
  logic [31:0] lba_q, lba_nxt;
  logic [1:0]  pending;
  logic        win;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [1:0]      err_q, err_nxt;
`else
  // Without the timeout the parameter only documents the interface.
  if (ACK_TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  assign pending = req_rd | req_wr;

  // last_q holds the index of the requester served most recently.
  always_comb begin
    if (pending == 2'b11) win = ~last_q;
    else                  win = pending[1];
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    done_nxt  = '0;
    last_nxt  = last_q;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    lba_nxt   = lba_q;
`ifdef SD_ARB_TIMEOUT_EN
    err_nxt    = '0;
    to_cnt_nxt = '0;
`endif
    case (state)
      IDLE: begin
        // A done pulse still visible in IDLE (timeout abort) acts as turnaround.
        if ((pending != 2'b00) && (done_q == 2'b00)) begin
          grant_nxt = win ? 2'b10 : 2'b01;
          lba_nxt   = win ? req_lba1 : req_lba0;
          wr_nxt    = req_wr[win];
          rd_nxt    = req_rd[win] & ~req_wr[win];
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (sd_ack) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = XFER;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          done_nxt  = grant_q;
          err_nxt   = grant_q;
          grant_nxt = '0;
          last_nxt  = grant_q[1];
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
`endif
      end
      XFER: begin
        if (!sd_ack) begin
          done_nxt  = grant_q;
          state_nxt = DONE;
        end
      end
      DONE: begin
        grant_nxt = '0;
        last_nxt  = grant_q[1];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      last_q  <= last_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      lba_q   <= lba_nxt;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err_q  <= '0;
    end else begin
      to_cnt <= to_cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  assign req_err = err_q;
`else
  assign req_err = '0;
`endif

  assign req_done        = done_q;
  assign req_grant       = grant_q;
  assign sd_lba          = lba_q;
  assign sd_rd           = rd_q;
  assign sd_wr           = wr_q;
  assign req_dout_strobe = grant_q & {2{sd_dout_strobe}};
  assign req_din_strobe  = grant_q & {2{sd_din_strobe}};
  assign sd_din          = grant_q[1] ? req_din1 :
                           grant_q[0] ? req_din0 : '0;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter; completion pulses are scoreboarded.
// Build with SD_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_sd_sector_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 50000;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [7:0]  req_din0, req_din1;
  logic [1:0]  req_done, req_err, req_grant, req_dout_strobe, req_din_strobe;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_dout_strobe, sd_din_strobe;
  logic [7:0]  sd_din;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb_q[$];

  sd_sector_arbiter #(.ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_lba0(req_lba0), .req_lba1(req_lba1),
    .req_din0(req_din0), .req_din1(req_din1),
    .req_done(req_done), .req_err(req_err), .req_grant(req_grant),
    .req_dout_strobe(req_dout_strobe), .req_din_strobe(req_din_strobe),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_dout_strobe(sd_dout_strobe), .sd_din_strobe(sd_din_strobe),
    .sd_din(sd_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Every done/err pulse must match the next expected {err, done} entry.
  always @(negedge clk_sys) begin
    if (reset_n && (req_done !== 2'b00 || req_err !== 2'b00)) begin
      if (sb_q.size() == 0) check("unexpected_done", 32'({req_err, req_done}), 32'h0);
      else                  check("sb_done_err", 32'({req_err, req_done}), 32'(sb_q.pop_front()));
    end
  end

  task automatic wait_cmd(input logic [1:0] g, input logic rd, input logic wr, input logic [31:0] lba);
    int unsigned n = 0;
    do begin
      tick(1);
      n++;
    end while (!(sd_rd || sd_wr) && n < 20);
    check("cmd_latency", n, 1);
    check("cmd_grant", 32'(req_grant), 32'(g));
    check("cmd_rd", 32'(sd_rd), 32'(rd));
    check("cmd_wr", 32'(sd_wr), 32'(wr));
    check("cmd_lba", sd_lba, lba);
  endtask

  task automatic finish_xfer(input logic [1:0] g, input logic [7:0] din, input logic [31:0] lba,
                             input logic [1:0] release_mask);
    logic [31:0] saved;
    tick(2);
    check("cmd_hold", 32'(sd_rd | sd_wr), 32'd1);
    sd_ack = 1'b1;
    tick(1);
    check("cmd_clear", 32'({sd_rd, sd_wr}), 32'd0);
    check("xfer_grant", 32'(req_grant), 32'(g));
    sd_dout_strobe = 1'b1;
    #1 check("dout_strobe", 32'(req_dout_strobe), 32'(g));
    sd_dout_strobe = 1'b0;
    sd_din_strobe = 1'b1;
    #1 check("din_strobe", 32'(req_din_strobe), 32'(g));
    check("sd_din", 32'(sd_din), 32'(din));
    sd_din_strobe = 1'b0;
    if (g[0]) begin saved = req_lba0; req_lba0 = '1; end
    else      begin saved = req_lba1; req_lba1 = '1; end
    tick(1);
    check("lba_stable", sd_lba, lba);
    if (g[0]) req_lba0 = saved;
    else      req_lba1 = saved;
    sd_ack = 1'b0;
    tick(1);
    check("done_pulse", 32'(req_done), 32'(g));
    check("done_err", 32'(req_err), 32'd0);
    check("done_lba", sd_lba, lba);
    req_rd = req_rd & ~release_mask;
    req_wr = req_wr & ~release_mask;
    tick(1);
    check("done_clear", 32'(req_done), 32'd0);
    check("idle_grant", 32'(req_grant), 32'd0);
    check("idle_cmd", 32'({sd_rd, sd_wr}), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  g;
    logic [31:0] lba;
    int unsigned n;

    reset_n = 1'b0;
    req_rd = '0; req_wr = '0;
    req_lba0 = '0; req_lba1 = '0;
    req_din0 = 8'h3C; req_din1 = 8'hA5;
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    tick(2);
    check("rst_rd", 32'(sd_rd), 32'd0);
    check("rst_wr", 32'(sd_wr), 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    check("rst_grant", 32'(req_grant), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_err", 32'(req_err), 32'd0);
    check("rst_din", 32'(sd_din), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Strobes with no owner are dropped.
    sd_dout_strobe = 1'b1; sd_din_strobe = 1'b1;
    #1 check("idle_dout_strobe", 32'(req_dout_strobe), 32'd0);
    check("idle_din_strobe", 32'(req_din_strobe), 32'd0);
    sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    tick(1);

    // Both requesting continuously: 0,1,0,1.
    req_lba0 = 32'h0000_1000; req_lba1 = 32'h0000_2000;
    req_rd = 2'b11;
    sb_q.push_back(4'b0001); sb_q.push_back(4'b0010);
    sb_q.push_back(4'b0001); sb_q.push_back(4'b0010);
    for (int i = 0; i < 4; i++) begin
      g   = (i % 2 == 1) ? 2'b10 : 2'b01;
      lba = g[1] ? req_lba1 : req_lba0;
      wait_cmd(g, 1'b1, 1'b0, lba);
      finish_xfer(g, g[1] ? req_din1 : req_din0, lba, (i == 3) ? 2'b11 : 2'b00);
    end

    // Requester 1 alone wins although it was granted last; rd+wr means write.
    req_lba1 = 32'hCAFE_0001;
    req_rd = 2'b10; req_wr = 2'b10;
    sb_q.push_back(4'b0010);
    wait_cmd(2'b10, 1'b0, 1'b1, 32'hCAFE_0001);
    finish_xfer(2'b10, 8'hA5, 32'hCAFE_0001, 2'b10);

    // Single read from requester 0.
    req_lba0 = 32'h0000_0123;
    req_rd = 2'b01;
    sb_q.push_back(4'b0001);
    wait_cmd(2'b01, 1'b1, 1'b0, 32'h0000_0123);
    finish_xfer(2'b01, 8'h3C, 32'h0000_0123, 2'b01);

    // Reset during XFER: silent abort, pointer back to requester 0.
    req_lba1 = 32'h0000_0777;
    req_rd = 2'b10;
    wait_cmd(2'b10, 1'b1, 1'b0, 32'h0000_0777);
    tick(1);
    sd_ack = 1'b1;
    tick(1);
    check("pre_rst_grant", 32'(req_grant), 32'd2);
    reset_n = 1'b0;
    #1 check("arst_grant", 32'(req_grant), 32'd0);
    check("arst_lba", sd_lba, 32'd0);
    check("arst_cmd", 32'({sd_rd, sd_wr}), 32'd0);
    check("arst_done", 32'(req_done), 32'd0);
    req_rd = 2'b00; sd_ack = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("post_rst_done", 32'(req_done), 32'd0);
    req_lba0 = 32'h0000_0010; req_lba1 = 32'h0000_0020;
    req_rd = 2'b11;
    sb_q.push_back(4'b0001); sb_q.push_back(4'b0010);
    wait_cmd(2'b01, 1'b1, 1'b0, 32'h0000_0010);
    finish_xfer(2'b01, 8'h3C, 32'h0000_0010, 2'b01);
    wait_cmd(2'b10, 1'b1, 1'b0, 32'h0000_0020);
    finish_xfer(2'b10, 8'hA5, 32'h0000_0020, 2'b10);

    req_lba0 = 32'h0000_0099;
    req_rd = 2'b01;
`ifdef SD_ARB_TIMEOUT_EN
    sb_q.push_back(4'b0101);
    wait_cmd(2'b01, 1'b1, 1'b0, 32'h0000_0099);
    n = 1;
    while (sd_rd && n < 40) begin
      tick(1);
      if (sd_rd) n++;
    end
    check("timeout_len", n, TO);
    check("timeout_done", 32'(req_done), 32'd1);
    check("timeout_err", 32'(req_err), 32'd1);
    req_rd = 2'b00;
    tick(1);
    check("timeout_clear", 32'({req_err, req_done}), 32'd0);
    check("timeout_grant", 32'(req_grant), 32'd0);
`else
    sb_q.push_back(4'b0001);
    wait_cmd(2'b01, 1'b1, 1'b0, 32'h0000_0099);
    n = 0;
    repeat (1000) begin
      tick(1);
      if (!sd_rd) n++;
    end
    check("no_timeout_drops", n, 0);
    check("no_timeout_rd", 32'(sd_rd), 32'd1);
    finish_xfer(2'b01, 8'h3C, 32'h0000_0099, 2'b01);
`endif

    tick(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
